// File: rtl/imem_loader.sv
// ---------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction memory loader. It receives a byte stream from a serial
// receiver, assembles 32-bit words and writes them to instruction memory. The
// CPU is held in reset for the whole session.
//
// Stream format: one header byte N (the word count, 1..2^ADDR_BIT), followed by
// N words of four bytes each, most significant byte first.
//
// Handshake (rx_valid / rx_ready): a byte is transferred on a rising edge
// where both rx_valid and rx_ready are high. The source holds rx_data and
// rx_valid stable until that edge. rx_valid while rx_ready is low is ignored.
// rx_ready depends only on the loader state, never on rx_valid.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   one-cycle pulse, begins a session from IDLE or ERROR
//   rx_data      in   [7:0] received byte
//   rx_valid     in   rx_data valid
//   rx_ready     out  loader accepts a byte this cycle
//   mem_we       out  one-cycle instruction memory write strobe
//   mem_addr     out  [31:0] byte address of the word being written
//   mem_wdata    out  [31:0] word being written
//   cpu_hold     out  holds the CPU in reset while high
//   done         out  last session completed
//   error        out  last session aborted (bad header or timeout)
//   words_loaded out  [ADDR_BIT:0] words written in current/last session
//   o_dbg_state  out  [2:0] FSM state: 0 IDLE, 1 HEADER, 2 DATA, 3 WRITE, 4 ERROR
// ---------------------------------------------------------------------------
module imem_loader #(
  parameter int ADDR_BIT = 6,
  parameter int TIMEOUT  = 1000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                cpu_hold,
  output logic                done,
  output logic                error,
  output logic [ADDR_BIT:0]   words_loaded,
  output logic [2:0]          o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_DATA   = 3'd2,
    S_WRITE  = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  // The idle counter only has to reach TIMEOUT-1.
  localparam int              TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [31:0]     MAX_N   = 32'(1) << ADDR_BIT;

  state_t              r_state;
  logic                r_rx_ready;
  logic                r_mem_we;
  logic [31:0]         r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_cpu_hold;
  logic                r_done;
  logic                r_error;
  logic [ADDR_BIT:0]   r_words_loaded;
  logic [ADDR_BIT:0]   r_n;
  logic [1:0]          r_byte_idx;
  logic [23:0]         r_shift;
  logic [TW-1:0]       r_to_cnt;

  logic                w_xfer;
  logic [31:0]         w_hdr;
  logic                w_hdr_bad;
  logic [31:0]         w_word;
  logic [ADDR_BIT:0]   w_words_inc;
  logic                w_timeout;

  assign w_xfer      = rx_valid && r_rx_ready;
  assign w_hdr       = {24'd0, rx_data};
  assign w_hdr_bad   = (w_hdr == 32'd0) || (w_hdr > MAX_N);
  assign w_word      = {r_shift, rx_data};
  assign w_words_inc = r_words_loaded + (ADDR_BIT + 1)'(1);
  assign w_timeout   = (r_to_cnt == TO_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_rx_ready     <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_addr     <= 32'd0;
      r_mem_wdata    <= 32'd0;
      r_cpu_hold     <= 1'b0;
      r_done         <= 1'b0;
      r_error        <= 1'b0;
      r_words_loaded <= '0;
      r_n            <= '0;
      r_byte_idx     <= 2'd0;
      r_shift        <= 24'd0;
      r_to_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (start) begin
            r_state        <= S_HEADER;
            r_rx_ready     <= 1'b1;
            r_cpu_hold     <= 1'b1;
            r_done         <= 1'b0;
            r_error        <= 1'b0;
            r_words_loaded <= '0;
            r_byte_idx     <= 2'd0;
            r_to_cnt       <= '0;
          end
        end

        S_HEADER: begin
          // A byte arriving on the timeout edge still counts.
          if (w_xfer) begin
            r_to_cnt <= '0;
            if (w_hdr_bad) begin
              r_state    <= S_ERROR;
              r_rx_ready <= 1'b0;
              r_error    <= 1'b1;
            end else begin
              r_state    <= S_DATA;
              r_n        <= w_hdr[ADDR_BIT:0];
              r_byte_idx <= 2'd0;
            end
          end else if (w_timeout) begin
            r_state    <= S_ERROR;
            r_rx_ready <= 1'b0;
            r_error    <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end

        S_DATA: begin
          if (w_xfer) begin
            r_to_cnt <= '0;
            r_shift  <= {r_shift[15:0], rx_data};
            if (r_byte_idx == 2'd3) begin
              // Word complete: present it to memory on the next cycle.
              r_state     <= S_WRITE;
              r_rx_ready  <= 1'b0;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= {{(30 - ADDR_BIT){1'b0}},
                              r_words_loaded[ADDR_BIT-1:0], 2'b00};
              r_mem_wdata <= w_word;
              r_byte_idx  <= 2'd0;
            end else begin
              r_byte_idx <= r_byte_idx + 2'd1;
            end
          end else if (w_timeout) begin
            r_state    <= S_ERROR;
            r_rx_ready <= 1'b0;
            r_error    <= 1'b1;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end

        S_WRITE: begin
          r_mem_we       <= 1'b0;
          r_words_loaded <= w_words_inc;
          if (w_words_inc == r_n) begin
            r_state    <= S_IDLE;
            r_done     <= 1'b1;
            r_cpu_hold <= 1'b0;
          end else begin
            r_state    <= S_DATA;
            r_rx_ready <= 1'b1;
            r_byte_idx <= 2'd0;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          r_rx_ready <= 1'b0;
          r_mem_we   <= 1'b0;
          r_cpu_hold <= 1'b0;
        end
      endcase
    end
  end

  assign rx_ready     = r_rx_ready;
  assign mem_we       = r_mem_we;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign cpu_hold     = r_cpu_hold;
  assign done         = r_done;
  assign error        = r_error;
  assign words_loaded = r_words_loaded;
  assign o_dbg_state  = r_state;

endmodule
